imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 172 +++++++++++++++++
 tb/tb_imem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Direct-mapped read-only instruction cache for the fetch unit.
// Hits answer one cycle after acceptance; misses refill a whole line word by word.
module imem_responder #(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_bytemask,
  input  logic        i_req_valid,
  input  logic        i_req_ready,
  input  logic        i_flush,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_valid,
  output logic        o_rsp_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_error
);

  localparam int unsigned OFF   = $clog2(LINE_WORDS);
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - OFF - IDX - 2;

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_REFILL = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [29:0]      lk_addr_q;
  logic             pending_q;
  logic             out_en_q;
  logic [SETS-1:0]  valid_q;
  logic [OFF-1:0]   cnt_q;
  logic             cancel_q;
  logic             mem_req_q;
  logic [31:0]      mem_addr_q;
  logic             error_q;

  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][LINE_WORDS];

  logic [OFF-1:0]   lk_word;
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [OFF-1:0]   cnt_inc;
  logic [31:0]      line_base;
  logic             hit_c;
  logic             legal_c;
  logic             last_c;
  logic             miss_c;
  logic             illegal_c;
  logic             accept_c;
  logic             rsp_valid_c;
  logic             rsp_ready_c;

  // The requester's ready is informational only; the response simply holds.
  logic unused_req_ready;
  assign unused_req_ready = i_req_ready;

  assign lk_word   = lk_addr_q[OFF-1:0];
  assign lk_idx    = lk_addr_q[OFF+IDX-1:OFF];
  assign lk_tag    = lk_addr_q[29:OFF+IDX];
  assign cnt_inc   = cnt_q + OFF'(1);
  assign line_base = {lk_tag, lk_idx, {(OFF+2){1'b0}}};
  assign last_c    = &cnt_q;
  assign legal_c   = (i_req_bytemask == 4'b1111) && (i_req_addr[1:0] == 2'b00);
  assign hit_c     = pending_q && valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_READY;
    else         state_q <= state_d;
  end

  // Next state plus the combinational handshake seen in the lookup cycle.
  always_comb begin
    state_d     = state_q;
    rsp_valid_c = 1'b0;
    rsp_ready_c = 1'b0;
    miss_c      = 1'b0;
    illegal_c   = 1'b0;
    accept_c    = 1'b0;
    unique case (state_q)
      ST_READY: begin
        rsp_valid_c = hit_c;
        miss_c      = pending_q && !hit_c;
        rsp_ready_c = out_en_q && !miss_c;
        illegal_c   = i_req_valid && rsp_ready_c && !legal_c;
        accept_c    = i_req_valid && rsp_ready_c && legal_c && !i_flush;
        if (miss_c)         state_d = ST_REFILL;
        else if (illegal_c) state_d = ST_ERROR;
      end
      ST_REFILL: begin
        if (i_mem_ack && last_c) state_d = ST_READY;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_READY;
    endcase
  end

  assign o_rsp_valid = rsp_valid_c;
  assign o_rsp_ready = rsp_ready_c;
  assign o_rsp_data  = rsp_valid_c ? data_mem[lk_idx][lk_word] : 32'h0;
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_error     = error_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lk_addr_q  <= '0;
      pending_q  <= 1'b0;
      out_en_q   <= 1'b0;
      valid_q    <= '0;
      cnt_q      <= '0;
      cancel_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      error_q    <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      if (i_flush) begin
        valid_q   <= '0;
        pending_q <= 1'b0;
      end
      unique case (state_q)
        ST_READY: begin
          if (miss_c) begin
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            cancel_q   <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= line_base;
          end else if (illegal_c) begin
            error_q <= 1'b1;
          end else if (accept_c) begin
            lk_addr_q <= i_req_addr[31:2];
            pending_q <= 1'b1;
          end
        end
        ST_REFILL: begin
          if (i_flush) cancel_q <= 1'b1;
          if (i_mem_ack) begin
            cnt_q <= cnt_inc;
            if (last_c) begin
              // A flush seen at any point of the refill leaves the line invalid.
              mem_req_q       <= 1'b0;
              valid_q[lk_idx] <= !(cancel_q || i_flush);
            end else begin
              mem_addr_q <= {lk_tag, lk_idx, cnt_inc, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_REFILL && i_mem_ack) begin
      data_mem[lk_idx][cnt_q] <= i_mem_data;
      if (last_c) tag_mem[lk_idx] <= lk_tag;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus queues expected responses and
// refill addresses; a response monitor and a memory model pop and compare.
module tb_imem_responder;

  typedef struct {
    logic        hit;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_bytemask = 4'hF;
  logic        req_valid = 1'b0;
  logic        req_ready = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        error;

  int n_chk = 0;
  int n_fail = 0;
  int ack_lat = 0;

  rsp_t        exp_rsp[$];
  logic [31:0] exp_mem[$];

  imem_responder dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_req_addr     (req_addr),
    .i_req_bytemask (req_bytemask),
    .i_req_valid    (req_valid),
    .i_req_ready    (req_ready),
    .i_flush        (flush),
    .o_rsp_data     (rsp_data),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_ready    (rsp_ready),
    .o_mem_addr     (mem_addr),
    .o_mem_req      (mem_req),
    .i_mem_ack      (mem_ack),
    .i_mem_data     (mem_data),
    .o_error        (error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response monitor: one check per accepted legal request.
  initial begin
    logic acc;
    rsp_t e;
    acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        acc = 1'b0;
      end else begin
        if (acc) begin
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexpected_accept", 32'd1, 32'd0);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.hit));
            if (e.hit) chk("rsp_data", rsp_data, e.data);
            else       chk("ready_in_miss", 32'(rsp_ready), 32'd0);
          end
        end
        acc = req_valid && rsp_ready && (req_bytemask == 4'hF) &&
              (req_addr[1:0] == 2'b00) && !flush;
      end
    end
  end

  // Backing memory model: acks after ack_lat idle cycles, checks address order and stability.
  initial begin
    logic        busy;
    logic [31:0] cur;
    logic [31:0] ea;
    int          wt;
    busy = 1'b0;
    cur  = '0;
    wt   = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rstn) begin
        busy = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cur  = mem_addr;
          wt   = ack_lat;
          if (exp_mem.size() == 0) begin
            chk("mem_unexpected_req", mem_addr, 32'hFFFF_FFFF);
          end else begin
            ea = exp_mem.pop_front();
            chk("mem_addr", cur, ea);
          end
        end else begin
          chk("mem_addr_hold", mem_addr, cur);
        end
        chk("ready_in_refill", 32'(rsp_ready), 32'd0);
        if (wt == 0) begin
          mem_ack  = 1'b1;
          mem_data = mw(cur);
          busy     = 1'b0;
        end else begin
          wt--;
        end
      end else if (busy) begin
        chk("mem_req_dropped", 32'(mem_req), 32'd1);
        busy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] a);
    req_addr  = a;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!rsp_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_timeout", 32'(rsp_ready), 32'd1);
  endtask

  task automatic push_miss(input logic [31:0] a);
    rsp_t e;
    e.hit  = 1'b0;
    e.data = '0;
    exp_rsp.push_back(e);
    for (int k = 0; k < 4; k++) exp_mem.push_back({a[31:4], 4'h0} + 32'(4 * k));
  endtask

  task automatic miss(input logic [31:0] a);
    int c;
    push_miss(a);
    issue(a);
    wait_ready(c);
  endtask

  task automatic hit(input logic [31:0] a);
    rsp_t e;
    e.hit  = 1'b1;
    e.data = mw(a);
    exp_rsp.push_back(e);
    issue(a);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_error",     32'(error),     32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    exp_rsp.delete();
    exp_mem.delete();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(rsp_ready), 32'd1);
  endtask

  initial begin
    int c;
    apply_reset();

    // Cold miss, then hit on the refilled word
    miss(32'h0000_0040);
    hit(32'h0000_0040);

    // Streaming hits across the resident line
    hit(32'h0000_0040);
    hit(32'h0000_0044);
    hit(32'h0000_0048);
    hit(32'h0000_004C);

    // Conflicting lines at index 0
    miss(32'h0000_0000);
    hit(32'h0000_0004);
    miss(32'h0000_0100);
    hit(32'h0000_0108);
    miss(32'h0000_0000);
    hit(32'h0000_000C);
    hit(32'h0000_0044);

    // Slow memory: three idle cycles before each ack
    ack_lat = 3;
    push_miss(32'h0000_0080);
    issue(32'h0000_0080);
    wait_ready(c);
    chk("slow_refill_at_least_16", 32'(c >= 16), 32'd1);
    ack_lat = 0;
    hit(32'h0000_008C);

    // Flush in the middle of a refill
    push_miss(32'h0000_0200);
    issue(32'h0000_0200);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_ready(c);
    miss(32'h0000_0200);
    hit(32'h0000_0204);
    miss(32'h0000_0040);
    hit(32'h0000_0048);

    // Flush coinciding with the last ack
    push_miss(32'h0000_0300);
    issue(32'h0000_0300);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_ready(c);
    miss(32'h0000_0300);
    hit(32'h0000_030C);

    // Illegal byte mask locks up the responder
    req_bytemask = 4'b0011;
    issue(32'h0000_0040);
    req_bytemask = 4'hF;
    req_addr     = 32'h0000_0040;
    req_valid    = 1'b1;
    repeat (3) begin
      chk("err_sticky", 32'(error), 32'd1);
      chk("err_ready",  32'(rsp_ready), 32'd0);
      chk("err_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    apply_reset();

    // Reset in the middle of a refill
    push_miss(32'h0000_0080);
    issue(32'h0000_0080);
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_refill_mem_req", 32'(mem_req), 32'd1);
    apply_reset();

    // Everything invalid after reset
    miss(32'h0000_0040);
    hit(32'h0000_0040);
    miss(32'h0000_0080);
    hit(32'h0000_0084);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
